// File: rtl/gemm_mem_streamer.sv
// gemm_mem_streamer: 2-D descriptor walker driving the banked scratchpad's
// 16-byte interface port. It issues one unaligned row access per row. In read
// mode the rows go out on a valid/ready stream. In write mode an incoming
// valid/ready stream becomes masked row writes.
// Optional feature: define GEMM_STREAMER_STALL_CNT_EN to add the stall_cycles
// counter output.
module gemm_mem_streamer #(
    parameter int NUM_RAMS = 16,
    parameter int D_WID    = 8,
    parameter int ADDR_W   = 32,
    parameter int ROWS_W   = 8
) (
`ifdef GEMM_STREAMER_STALL_CNT_EN
    output logic [31:0]               stall_cycles,
`endif
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      cfg_dir,
    input  logic [ADDR_W-1:0]         cfg_base,
    input  logic [ADDR_W-1:0]         cfg_stride,
    input  logic [ROWS_W-1:0]         cfg_rows,
    input  logic [4:0]                cfg_len,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_RAMS*D_WID-1:0] rd_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    input  logic [NUM_RAMS*D_WID-1:0] wr_data,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    output logic                      mem_en,
    output logic                      mem_rdwr,
    output logic [4:0]                mem_control,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [NUM_RAMS*D_WID-1:0] mem_wr_data,
    input  logic [NUM_RAMS*D_WID-1:0] mem_rd_data
);
    localparam int DW = NUM_RAMS * D_WID;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_DRAIN, S_WR, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ROWS_W-1:0] rows_q, rows_d;
    logic [4:0]        len_q, len_d;

    logic              inflight_q;
    logic [1:0]        cnt_q;
    logic              rd_ptr_q, wr_ptr_q;
    logic [DW-1:0]     fifo_q [2];

    logic              push, pop, rd_issue, wr_hs;
    logic [1:0]        occ;

    // Datapath handshakes and port outputs derived from the current state.
    // The issue rule credits a same-cycle pop so that a consumer holding
    // rd_ready high sees one row per cycle without ever overflowing the FIFO.
    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        rd_valid    = (cnt_q != 2'd0);
        pop         = rd_valid && rd_ready;
        push        = inflight_q;
        occ         = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        rd_issue    = (state_q == S_RD) && (rows_q != '0) && (occ < 2'd2);
        wr_ready    = (state_q == S_WR) && (rows_q != '0);
        wr_hs       = wr_ready && wr_valid;
        mem_en      = rd_issue || wr_hs;
        mem_rdwr    = wr_hs;
        mem_control = len_q;
        mem_addr    = addr_q;
        mem_wr_data = wr_data;
        rd_data     = fifo_q[rd_ptr_q];
    end

    // Next-state logic: descriptor latch, row walking and job sequencing.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        rows_d   = rows_q;
        len_d    = len_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = cfg_base;
                    stride_d = cfg_stride;
                    rows_d   = cfg_rows;
                    len_d    = (cfg_len > 5'd16) ? 5'd16 : cfg_len;
                    if (cfg_rows == '0) state_d = S_DONE;
                    else if (cfg_dir)   state_d = S_WR;
                    else                state_d = S_RD;
                end
            end
            S_RD: begin
                if (rd_issue) begin
                    addr_d = addr_q + stride_q;
                    rows_d = rows_q - ROWS_W'(1);
                    if (rows_q == ROWS_W'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave as soon as the last buffered row is being popped.
                if (!inflight_q && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)))
                    state_d = S_DONE;
            end
            S_WR: begin
                if (wr_hs) begin
                    addr_d = addr_q + stride_q;
                    rows_d = rows_q - ROWS_W'(1);
                    if (rows_q == ROWS_W'(1)) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers; reset abandons any job in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            rows_q   <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            rows_q   <= rows_d;
            len_q    <= len_d;
        end
    end

    // Read-return FIFO bookkeeping; clearing inflight drops data issued before reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            cnt_q      <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else begin
            inflight_q <= rd_issue;
            cnt_q      <= cnt_q + {1'b0, push} - {1'b0, pop};
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // FIFO storage captures memory read lanes one cycle after each issue.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= mem_rd_data;
    end

`ifdef GEMM_STREAMER_STALL_CNT_EN
    logic [31:0] stall_q;
    logic        stall_ev;

    // Stall event: output stalled by consumer, or input starved by producer.
    always_comb begin
        stall_ev = busy && ((rd_valid && !rd_ready) || (wr_ready && !wr_valid));
    end

    // Saturating stall counter, restarted on every accepted job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               stall_q <= '0;
        else if ((state_q == S_IDLE) && start) stall_q <= '0;
        else if (stall_ev && (stall_q != '1))  stall_q <= stall_q + 32'd1;
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_gemm_mem_streamer.sv
// Randomized scoreboard bench for gemm_mem_streamer with directed corner jobs.
module tb_gemm_mem_streamer;
    logic         clk = 1'b0;
    logic         rst, start, cfg_dir;
    logic [31:0]  cfg_base, cfg_stride;
    logic [7:0]   cfg_rows;
    logic [4:0]   cfg_len;
    logic         busy, done, rd_valid, rd_ready, wr_valid, wr_ready;
    logic         mem_en, mem_rdwr;
    logic [4:0]   mem_control;
    logic [31:0]  mem_addr;
    logic [127:0] rd_data, wr_data, mem_wr_data, mem_rd_data;

    gemm_mem_streamer dut (
        .clk(clk), .rst(rst), .start(start), .cfg_dir(cfg_dir),
        .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_rows(cfg_rows),
        .cfg_len(cfg_len), .busy(busy), .done(done), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .wr_data(wr_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .mem_en(mem_en),
        .mem_rdwr(mem_rdwr), .mem_control(mem_control), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rdwr;
        logic [4:0]   ctrl;
        logic [31:0]  addr;
        logic [127:0] data;
    } iss_t;

    iss_t         iss_q[$];
    logic [127:0] beat_q[$];
    iss_t         mon_e;
    int           checks = 0, errors = 0, issues = 0;
    int           rd_prob = 100;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Memory contents: a fixed hash of the byte address.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E3779B1;
        return h[31:24] ^ h[15:8];
    endfunction

    // A row as the memory returns it: bytes at a..a+len-1, zeros above.
    function automatic logic [127:0] ref_row(input logic [31:0] a, input int len);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            if (i < len) r[i*8 +: 8] = mem_byte(a + 32'(i));
        return r;
    endfunction

    function automatic int clamp_len(input int len);
        return (len > 16) ? 16 : len;
    endfunction

    // Scratchpad model: read lanes valid exactly one cycle after a read issue, junk otherwise.
    always @(posedge clk) begin
        if (mem_en && !mem_rdwr) mem_rd_data <= ref_row(mem_addr, int'(mem_control));
        else                     mem_rd_data <= {$urandom, $urandom, $urandom, $urandom};
    end

    // Monitor: pops expected issues and beats whenever the DUT presents them.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) begin
                issues++;
                if (iss_q.size() == 0) begin
                    check("unexpected_issue", {95'd0, mem_rdwr, mem_addr}, 128'd0);
                end else begin
                    mon_e = iss_q.pop_front();
                    check("issue_addr", mem_addr, mon_e.addr);
                    check("issue_rdwr", mem_rdwr, mon_e.rdwr);
                    check("issue_ctrl", mem_control, mon_e.ctrl);
                    if (mon_e.rdwr) begin
                        check("issue_wdata", mem_wr_data, mon_e.data);
                        check("issue_on_handshake", wr_valid && wr_ready, 1);
                    end
                end
            end
            if (done) check("done_without_mem_en", mem_en, 0);
            if (rd_valid && rd_ready) begin
                if (beat_q.size() == 0) check("unexpected_beat", rd_data, 128'd0 - 1);
                else                    check("rd_data", rd_data, beat_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rd_ready = ($urandom_range(0, 99) < rd_prob);
    endtask

    // Queue the expected read traffic, then pulse start for one cycle.
    task automatic launch(input bit dir, input logic [31:0] base, input logic [31:0] stride,
                          input int rows, input int len);
        int cl;
        cl = clamp_len(len);
        if (!dir) begin
            for (int i = 0; i < rows; i++) begin
                iss_q.push_back('{1'b0, 5'(cl), base + stride * 32'(i), 128'd0});
                beat_q.push_back(ref_row(base + stride * 32'(i), cl));
            end
        end
        cfg_dir = dir; cfg_base = base; cfg_stride = stride;
        cfg_rows = 8'(rows); cfg_len = 5'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_dir = $urandom_range(0, 1); cfg_base = $urandom; cfg_stride = $urandom;
        cfg_rows = 8'($urandom); cfg_len = 5'($urandom);
    endtask

    // Drive write rows (if any), then wait for done and check the job closed cleanly.
    task automatic finish_job(input bit dir, input logic [31:0] base, input logic [31:0] stride,
                              input int rows, input int len, input int wprob, input bit toggle);
        logic [127:0] d;
        bit hs, phase;
        int n;
        phase = 1'b1;
        if (dir) begin
            for (int i = 0; i < rows; i++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                iss_q.push_back('{1'b1, 5'(clamp_len(len)), base + stride * 32'(i), d});
                wr_data = d;
                hs = 1'b0;
                n = 0;
                while (!hs && n < 200) begin
                    wr_valid = toggle ? phase : ($urandom_range(0, 99) < wprob);
                    phase = ~phase;
                    @(negedge clk);
                    hs = wr_valid && wr_ready;
                    tick();
                    n++;
                end
                if (!hs) check("wr_handshake_timeout", 0, 1);
            end
            wr_valid = 1'b0;
            if (rows > 0) check("done_after_last_wr", done, 1);
        end
        n = 0;
        while (!done && n < 500) begin
            tick();
            n++;
        end
        check("done_seen", done, 1);
        tick();
        check("idle_after_done", {busy, done}, 0);
        check("iss_q_drained", iss_q.size(), 0);
        check("beat_q_drained", beat_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b, s;
        int r, l, n0;
        bit d, stray;

        rst = 1'b1; start = 1'b0; cfg_dir = 1'b0; cfg_base = '0; cfg_stride = '0;
        cfg_rows = '0; cfg_len = '0; rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {busy, done, rd_valid, wr_ready, mem_en, mem_rdwr}, 0);
        check("reset_mem_control", mem_control, 0);
        check("reset_mem_addr", mem_addr, 0);
        @(negedge clk) rst = 1'b0;
        tick();

        // Full-rate read: issue latency, consecutive beats, done right after last pop.
        rd_prob = 100; rd_ready = 1'b1;
        launch(0, 32'h20, 32'd16, 4, 16);
        check("first_issue_cycle1", mem_en, 1);
        check("busy_in_job", busy, 1);
        tick();
        tick();
        check("rd_valid_cycle3", rd_valid, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rd_valid_consecutive", rd_valid, 1);
        end
        tick();
        check("done_after_last_pop", done, 1);
        finish_job(0, 32'h20, 32'd16, 4, 16, 100, 0);

        // Unaligned short rows.
        launch(0, 32'h23, 32'h40, 2, 5);
        finish_job(0, 32'h23, 32'h40, 2, 5, 100, 0);

        // Backpressure: two issues fill the buffer, then the issuer stalls.
        rd_prob = 0; rd_ready = 1'b0;
        n0 = issues;
        launch(0, 32'h1000, 32'h10, 4, 16);
        repeat (10) tick();
        check("issues_while_stalled", issues - n0, 2);
        check("stalled_rd_valid", rd_valid, 1);
        check("stalled_rd_data_row0", rd_data, ref_row(32'h1000, 16));
        rd_prob = 100;
        finish_job(0, 32'h1000, 32'h10, 4, 16, 100, 0);

        // Write with wr_valid alternating 1/0.
        launch(1, 32'h400, 32'h30, 3, 16);
        finish_job(1, 32'h400, 32'h30, 3, 16, 100, 1);

        // Empty job.
        n0 = issues;
        launch(0, 32'h80, 32'h10, 0, 16);
        check("empty_job_done", done, 1);
        finish_job(0, 32'h80, 32'h10, 0, 16, 100, 0);
        check("empty_job_no_issue", issues - n0, 0);

        // start while busy is ignored.
        launch(0, 32'h200, 32'h20, 3, 9);
        cfg_dir = 1'b1; cfg_rows = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        finish_job(0, 32'h200, 32'h20, 3, 9, 100, 0);

        // Address wrap past 2^32.
        launch(0, 32'hFFFF_FFF0, 32'd16, 2, 16);
        finish_job(0, 32'hFFFF_FFF0, 32'd16, 2, 16, 100, 0);

        // Asynchronous reset with two rows in flight.
        rd_prob = 0; rd_ready = 1'b0;
        launch(0, 32'h300, 32'h10, 4, 16);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midjob_reset_outputs", {busy, rd_valid, mem_en, done}, 0);
        iss_q.delete();
        beat_q.delete();
        @(negedge clk) rst = 1'b0;
        rd_prob = 100;
        stray = 1'b0;
        repeat (6) begin
            tick();
            if (rd_valid || busy) stray = 1'b1;
        end
        check("no_activity_after_reset", stray, 0);

        // Randomized jobs.
        for (int j = 0; j < 30; j++) begin
            d = $urandom_range(0, 1);
            r = $urandom_range(0, 6);
            l = $urandom_range(0, 20);
            b = $urandom;
            case ($urandom_range(0, 2))
                0:       s = 32'd16;
                1:       s = $urandom_range(0, 64);
                default: s = $urandom;
            endcase
            rd_prob = $urandom_range(30, 100);
            launch(d, b, s, r, l);
            finish_job(d, b, s, r, l, $urandom_range(30, 100), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
